// File: rtl/cache_types_package.sv
// Shared cache type definitions for the data-cache memory controller.
// Holds the cache geometry (words per block, address field widths), the
// word and RAM handshake types, the miss-address layout and the controller
// FSM states. It also provides a helper that builds a word-aligned RAM
// address from a tag, an index and a word offset.
package cache_types_package;

  localparam int WORDS      = 2;
  localparam int WORD_COUNT = $clog2(WORDS);

  localparam int DTAG_W = 26;
  localparam int DIDX_W = 3;
  localparam int DBLK_W = 1;
  localparam int DBYT_W = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic [DBLK_W-1:0] blkoff;
    logic [DBYT_W-1:0] bytoff;
  } dcachef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } dmemctrl_state_t;

  // Word address inside a block; the byte offset is always zero.
  function automatic word_t word_addr(input logic [DTAG_W-1:0] tag,
                                      input logic [DIDX_W-1:0] idx,
                                      input logic [DBLK_W-1:0] blk);
    return {tag, idx, blk, {DBYT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_mem_ctrl.sv
// Data-cache miss service controller.
// On a miss request it optionally writes the dirty victim block back to RAM
// one word at a time, then fetches the missing block word by word and
// presents it on fill_data together with a one-cycle done pulse.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   req, req_addr        miss request and miss address (dcachef_t layout)
//   wb_en, wb_tag,       victim dirty flag, victim tag and victim block
//   wb_data
//   busy, done           service in progress / block delivered (pulse)
//   fill_data            fetched block, held until the next fill capture
//   ramREN, ramWEN,      RAM read/write strobes, word address, write data
//   ramaddr, ramstore
//   ramload, ramstate    RAM read data and handshake state
module dcache_mem_ctrl
  import cache_types_package::*;
#(
  parameter int WORDS = cache_types_package::WORDS
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req,
  input  logic [31:0]              req_addr,
  input  logic                     wb_en,
  input  logic [DTAG_W-1:0]        wb_tag,
  input  word_t [WORDS-1:0]        wb_data,
  output logic                     busy,
  output logic                     done,
  output word_t [WORDS-1:0]        fill_data,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [31:0]              ramaddr,
  output logic [31:0]              ramstore,
  input  logic [31:0]              ramload,
  input  ramstate_t                ramstate
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  dmemctrl_state_t   state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DTAG_W-1:0] req_tag_q;
  logic [DIDX_W-1:0] req_idx_q;
  logic [DTAG_W-1:0] wb_tag_q;
  word_t [WORDS-1:0] wb_data_q;
  word_t [WORDS-1:0] fill_data_q;
  logic              busy_q;
  logic              done_q;
  logic              ren_q;
  logic              wen_q;
  logic [31:0]       ramaddr_q;
  logic [31:0]       ramstore_q;

  dcachef_t          req_f_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              cnt_last_s;
  logic              unused_s;

  assign req_f_s    = dcachef_t'(req_addr);
  assign cnt_nxt_s  = cnt_q + CNT_W'(1);
  assign cnt_last_s = (cnt_q == CNT_LAST);
  // Block and byte offsets of the miss address never reach the RAM address.
  assign unused_s   = ^{req_f_s.blkoff, req_f_s.bytoff};

  // Controller FSM: state, word counter, latches and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      ramaddr_q   <= 32'h0000_0000;
      ramstore_q  <= 32'h0000_0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            req_tag_q <= req_f_s.tag;
            req_idx_q <= req_f_s.idx;
            wb_tag_q  <= wb_tag;
            wb_data_q <= wb_data;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            // The chosen next state records whether a write-back is due.
            if (wb_en) begin
              state_q    <= WB;
              wen_q      <= 1'b1;
              ramaddr_q  <= word_addr(wb_tag, req_f_s.idx, DBLK_W'(0));
              ramstore_q <= wb_data[0];
            end else begin
              state_q   <= FILL;
              ren_q     <= 1'b1;
              ramaddr_q <= word_addr(req_f_s.tag, req_f_s.idx, DBLK_W'(0));
            end
          end
        end
        WB: begin
          // FREE/BUSY/ERROR leave everything in place so the word is re-issued.
          if (ramstate == ACCESS) begin
            if (cnt_last_s) begin
              cnt_q      <= '0;
              state_q    <= FILL;
              wen_q      <= 1'b0;
              ren_q      <= 1'b1;
              ramaddr_q  <= word_addr(req_tag_q, req_idx_q, DBLK_W'(0));
              ramstore_q <= 32'h0000_0000;
            end else begin
              cnt_q      <= cnt_nxt_s;
              ramaddr_q  <= word_addr(wb_tag_q, req_idx_q, DBLK_W'(cnt_nxt_s));
              ramstore_q <= wb_data_q[cnt_nxt_s];
            end
          end
        end
        FILL: begin
          if (ramstate == ACCESS) begin
            fill_data_q[cnt_q] <= ramload;
            if (cnt_last_s) begin
              cnt_q   <= '0;
              state_q <= DONE;
              ren_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q     <= cnt_nxt_s;
              ramaddr_q <= word_addr(req_tag_q, req_idx_q, DBLK_W'(cnt_nxt_s));
            end
          end
        end
        DONE: begin
          // A req seen here is left for IDLE to accept on the next cycle.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fill_data = fill_data_q;
  assign ramREN    = ren_q;
  assign ramWEN    = wen_q;
  assign ramaddr   = ramaddr_q;
  assign ramstore  = ramstore_q;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed self-checking bench for dcache_mem_ctrl (WORDS = 2).
module tb_dcache_mem_ctrl;
  import cache_types_package::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req;
  logic [31:0] req_addr;
  logic        wb_en;
  logic [25:0] wb_tag;
  logic [63:0] wb_data;
  logic        busy;
  logic        done;
  logic [63:0] fill_data;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int tests = 0;
  int fails = 0;

  dcache_mem_ctrl #(.WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_addr(req_addr), .wb_en(wb_en),
    .wb_tag(wb_tag), .wb_data(wb_data), .busy(busy), .done(done),
    .fill_data(fill_data), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks busy/done/strobes/address together for one cycle.
  task automatic chk_bus(input string tag, input logic b, input logic d,
                         input logic r, input logic w, input logic [31:0] a);
    chk({tag, ".busy"},  64'(busy),    64'(b));
    chk({tag, ".done"},  64'(done),    64'(d));
    chk({tag, ".ren"},   64'(ramREN),  64'(r));
    chk({tag, ".wen"},   64'(ramWEN),  64'(w));
    chk({tag, ".addr"},  64'(ramaddr), 64'(a));
  endtask

  initial begin
    nRST = 1'b0; req = 1'b0; req_addr = 32'h0; wb_en = 1'b0; wb_tag = 26'h0;
    wb_data = 64'h0; ramload = 32'h0; ramstate = FREE;

    // Reset state
    tick(); tick();
    chk_bus("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst.store", 64'(ramstore), 64'h0);
    chk("rst.fill",  fill_data,     64'h0);
    nRST = 1'b1;
    tick();
    chk_bus("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Clean fill at 0x48
    req = 1'b1; req_addr = 32'h0000_0048; wb_en = 1'b0; ramstate = ACCESS;
    tick();
    req = 1'b0; ramload = 32'hA0;
    chk_bus("c1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h48);
    tick();
    ramload = 32'hA1;
    chk_bus("c2", 1'b1, 1'b0, 1'b1, 1'b0, 32'h4C);
    tick();
    chk_bus("c3", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4C);
    chk("c3.fill", fill_data, 64'h0000_00A1_0000_00A0);
    ramload = 32'hFFFF_FFFF;
    tick();
    chk("c4.busy", 64'(busy), 64'h0);
    chk("c4.done", 64'(done), 64'h0);
    chk("c4.fill", fill_data, 64'h0000_00A1_0000_00A0);

    // Dirty miss: write back tag 1 then fill from 0x10
    req = 1'b1; req_addr = 32'h0000_0010; wb_en = 1'b1; wb_tag = 26'h1;
    wb_data = 64'h0000_0022_0000_0011;
    tick();
    req = 1'b0; wb_en = 1'b0; wb_data = 64'h0; wb_tag = 26'h0;
    chk_bus("d1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h50);
    chk("d1.store", 64'(ramstore), 64'h11);
    tick();
    chk_bus("d2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h54);
    chk("d2.store", 64'(ramstore), 64'h22);
    tick();
    ramload = 32'hB0;
    chk_bus("d3", 1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
    tick();
    ramload = 32'hB1;
    chk_bus("d4", 1'b1, 1'b0, 1'b1, 1'b0, 32'h14);
    tick();
    chk_bus("d5", 1'b1, 1'b1, 1'b0, 1'b0, 32'h14);
    chk("d5.fill", fill_data, 64'h0000_00B1_0000_00B0);
    tick();

    // Wait states: three BUSY cycles ahead of each ACCESS, fill at 0x80
    req = 1'b1; req_addr = 32'h0000_0080; ramstate = BUSY; ramload = 32'hDEAD_BEEF;
    tick();
    req = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 3; k++) begin
        chk_bus($sformatf("ws%0d_%0d", w, k), 1'b1, 1'b0, 1'b1, 1'b0, 32'h80 + 32'(4 * w));
        tick();
      end
      chk_bus($sformatf("ws%0d_acc", w), 1'b1, 1'b0, 1'b1, 1'b0, 32'h80 + 32'(4 * w));
      if (w == 0) chk("ws.hold", fill_data, 64'h0000_00B1_0000_00B0);
      ramstate = ACCESS; ramload = 32'hC0 + 32'(w);
      tick();
      ramstate = BUSY; ramload = 32'hDEAD_BEEF;
    end
    chk_bus("ws.done", 1'b1, 1'b1, 1'b0, 1'b0, 32'h84);
    chk("ws.fill", fill_data, 64'h0000_00C1_0000_00C0);
    ramstate = ACCESS;
    tick();

    // ERROR on the first fill word, then ACCESS; fill at 0xC8
    req = 1'b1; req_addr = 32'h0000_00C8;
    tick();
    req = 1'b0; ramstate = ERROR; ramload = 32'h0000_DEAD;
    chk_bus("e1", 1'b1, 1'b0, 1'b1, 1'b0, 32'hC8);
    tick();
    ramstate = ACCESS; ramload = 32'hE0;
    chk_bus("e2", 1'b1, 1'b0, 1'b1, 1'b0, 32'hC8);
    chk("e2.fill", fill_data, 64'h0000_00C1_0000_00C0);
    tick();
    ramload = 32'hE1;
    chk_bus("e3", 1'b1, 1'b0, 1'b1, 1'b0, 32'hCC);
    tick();
    chk_bus("e4", 1'b1, 1'b1, 1'b0, 1'b0, 32'hCC);
    chk("e4.fill", fill_data, 64'h0000_00E1_0000_00E0);
    tick();

    // Reset during the second write-back word
    req = 1'b1; req_addr = 32'h0000_0018; wb_en = 1'b1; wb_tag = 26'h5;
    wb_data = 64'h0000_0044_0000_0033;
    tick();
    req = 1'b0; wb_en = 1'b0;
    chk_bus("r1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h158);
    tick();
    chk_bus("r2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h15C);
    chk("r2.store", 64'(ramstore), 64'h44);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk_bus("r3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("r3.fill", fill_data, 64'h0);
    tick();
    chk_bus("r4", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    req = 1'b1; req_addr = 32'h0000_0048;
    tick();
    req = 1'b0; ramload = 32'h55;
    chk_bus("r5", 1'b1, 1'b0, 1'b1, 1'b0, 32'h48);
    tick();
    ramload = 32'h66;
    tick();
    chk_bus("r6", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4C);
    chk("r6.fill", fill_data, 64'h0000_0066_0000_0055);
    tick();

    // req held high: one IDLE cycle between done and the next service
    req = 1'b1; req_addr = 32'h0000_0048; ramload = 32'h77;
    tick();
    chk_bus("b1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h48);
    tick(); tick();
    chk_bus("b2", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4C);
    tick();
    chk("b3.busy", 64'(busy), 64'h0);
    chk("b3.done", 64'(done), 64'h0);
    tick();
    req = 1'b0; ramload = 32'h88;
    chk_bus("b4", 1'b1, 1'b0, 1'b1, 1'b0, 32'h48);
    tick(); tick();
    chk_bus("b5", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4C);
    chk("b5.fill", fill_data, 64'h0000_0088_0000_0088);
    tick(); tick();
    chk_bus("b6", 1'b0, 1'b0, 1'b0, 1'b0, 32'h4C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_mem_ctrl.md
DCACHE_MEM_CTRL -- requirements
Module: dcache_mem_ctrl

Interface
REQ-001 Parameter WORDS, default 2 (cache_types_package), words per block; WORD_COUNT = $clog2(WORDS) counter width.
REQ-002 Parameter DTAG_W/DIDX_W/DBLK_W/DBYT_W, defaults 26/3/1/2 (package), address field widths; sum SHALL equal 32.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 nRST  in  1  reset; synchronous, active-low.
REQ-005 req  in  1  miss service request from dcache.
REQ-006 req_addr  in  32  miss address, dcachef_t layout.
REQ-007 wb_en  in  1  victim dirty; write back before fill.
REQ-008 wb_tag  in  DTAG_W  victim tag.
REQ-009 wb_data  in  WORDS*32  victim block, word_t[WORDS].
REQ-010 busy  out  1  request held, service in progress.
REQ-011 done  out  1  one-cycle pulse; fill_data valid.
REQ-012 fill_data  out  WORDS*32  fetched block, word_t[WORDS].
REQ-013 ramREN / ramWEN  out  1 each  RAM read / write strobe; never both high.
REQ-014 ramaddr  out  32  RAM word address; ramstore  out  32  write data; ramload  in  32  read data.
REQ-015 ramstate  in  2  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-016 FSM states SHALL be IDLE, WB, FILL, DONE.
REQ-017 IDLE: on req=1, latch req_addr, wb_en, wb_tag, wb_data; clear word counter; go WB if wb_en else FILL.
REQ-018 busy SHALL be 1 in WB, FILL, DONE; 0 in IDLE.
REQ-019 req while busy=1 SHALL be ignored; a req present during DONE is accepted the cycle after, in IDLE.
REQ-020 WB: ramWEN=1, ramaddr={wb_tag, idx, cnt, 2'b00}, ramstore=latched wb_data[cnt].
REQ-021 FILL: ramREN=1, ramaddr={tag, idx, cnt, 2'b00}; on ACCESS capture ramload into fill_data[cnt].
REQ-022 Counter advances only on ramstate==ACCESS; FREE/BUSY hold state, counter, strobes.
REQ-023 ERROR: hold state and counter, re-issue the same word next cycle; no data captured.
REQ-024 ACCESS with cnt==WORDS-1: counter wraps to 0; WB->FILL, FILL->DONE.
REQ-025 DONE: done=1 for exactly one cycle, fill_data stable; next state IDLE.
REQ-026 fill_data SHALL hold its value until the next FILL capture.
REQ-027 Minimum latency (ACCESS every cycle), req to done: 2*WORDS+1 cycles with wb_en, WORDS+1 without.
REQ-028 Address bytoff bits SHALL always be 2'b00; blkoff of req_addr is ignored.

Reset
REQ-029 nRST=0 at a rising edge: state IDLE, counter 0, latches and fill_data 0.
REQ-030 Reset mid-WB/FILL: abort; ramREN=ramWEN=0, busy=0, done=0 from the following cycle; no done pulse.
REQ-031 Outputs after reset: busy=0, done=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, fill_data=0.

Structure
REQ-032 dmemctrl_state_t enum (IDLE, WB, FILL, DONE) SHALL be added to cache_types_package; word_t, dcachef_t, ramstate_t reused from it.
REQ-033 Single module; no sub-module; word counter inline, WORD_COUNT wide.

Verification
REQ-034 Clean fill: req_addr=0x0000_0048, wb_en=0, ACCESS every cycle, ramload 0xA0,0xA1 -> ramaddr 0x48,0x4C; done at cycle 3; fill_data={0xA1,0xA0}.
REQ-035 Dirty miss: wb_en=1, wb_tag=0x1, wb_data={0x22,0x11}, req_addr=0x0000_0010 -> writes 0x11@0x50, 0x22@0x54, then reads 0x10, 0x14; done at cycle 5.
REQ-036 Wait states: ramstate BUSY for 3 cycles before each ACCESS -> ramaddr and strobes stable throughout; done at cycle 9 (clean fill).
REQ-037 ERROR on first FILL word, then ACCESS -> same ramaddr re-issued; fill_data word 0 from the ACCESS cycle only.
REQ-038 nRST=0 during second WB word -> next cycle busy=0, ramWEN=0, no done; new req afterwards serviced normally.
REQ-039 req held high continuously -> back-to-back services with one IDLE cycle between done and next busy.
